// File: rtl/sha3_theta_elts.sv
// sha3_theta_elts: two-stage Keccak theta column-correction (D) generator.
// Stage 1 registers column parities C; stage 2 produces D and forwards the state.
module sha3_theta_elts #(
  parameter string LOGIC_STYLE = "basic"
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sample,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  output logic [4:0][63:0] osa,
  output logic [4:0][63:0] osb,
  output logic [4:0][63:0] osc,
  output logic [4:0][63:0] osd,
  output logic [4:0][63:0] ose,
  output logic [4:0][63:0] elt,
  output logic             ovalid
);
  if (LOGIC_STYLE != "basic") begin : g_bad_style
    $error("sha3_theta_elts: unsupported LOGIC_STYLE %s", LOGIC_STYLE);
  end
  logic [4:0][63:0] w_c, w_d;
  logic [4:0][63:0] r_c, r_sa, r_sb, r_sc, r_sd, r_se;
  logic             r_v1;
  logic [4:0][63:0] r_elt, r_osa, r_osb, r_osc, r_osd, r_ose;
  logic             r_ovalid;
  for (genvar x = 0; x < 5; x++) begin : g_col
    assign w_c[x] = isa[x] ^ isb[x] ^ isc[x] ^ isd[x] ^ ise[x];
    // D[x] = C[x-1] ^ rotl1(C[x+1]), indices mod 5
    assign w_d[x] = r_c[(x + 4) % 5] ^ {r_c[(x + 1) % 5][62:0], r_c[(x + 1) % 5][63]};
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      r_c  <= '0;
      r_sa <= '0;
      r_sb <= '0;
      r_sc <= '0;
      r_sd <= '0;
      r_se <= '0;
    end else begin
      r_v1 <= sample;
      if (sample) begin
        r_c  <= w_c;
        r_sa <= isa;
        r_sb <= isb;
        r_sc <= isc;
        r_sd <= isd;
        r_se <= ise;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovalid <= 1'b0;
      r_elt    <= '0;
      r_osa    <= '0;
      r_osb    <= '0;
      r_osc    <= '0;
      r_osd    <= '0;
      r_ose    <= '0;
    end else begin
      r_ovalid <= r_v1;
      if (r_v1) begin
        r_elt <= w_d;
        r_osa <= r_sa;
        r_osb <= r_sb;
        r_osc <= r_sc;
        r_osd <= r_sd;
        r_ose <= r_se;
      end
    end
  end
  assign ovalid = r_ovalid;
  assign elt    = r_elt;
  assign osa    = r_osa;
  assign osb    = r_osb;
  assign osc    = r_osc;
  assign osd    = r_osd;
  assign ose    = r_ose;
endmodule
